// File: rtl/rr_mux_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
package rr_mux_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;

    typedef logic [$clog2(N_REQ_DEF)-1:0] idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate by ptr, find first set, rotate back.
module rr_pick
    import rr_mux_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    g
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IW-1:0]      off;

    assign dbl = {valid, valid} >> ptr;
    assign rot = dbl[N_REQ-1:0];
    assign any = |valid;

    // Downward scan so the lowest set bit wins.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
    end

    assign g = ptr + off;
endmodule

// File: rtl/rr_mux_arbiter.sv
// N-way round-robin arbiter feeding a single registered output channel.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [IW-1:0]      out_src,
    input  logic               out_ready
);
    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   g;
    logic            any;
    logic            load;
    logic [W-1:0]    data_q;
    logic [IW-1:0]   src_q;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .valid(req_valid),
        .ptr  (ptr),
        .any  (any),
        .g    (g)
    );

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign load      = any && (!out_valid || out_ready);

    always_comb begin
        req_ready = '0;
        if (load) req_ready[g] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (any) state_d = FULL;
            FULL:  if (out_ready && !any) state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr     <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q <= req_data[g*W +: W];
                src_q  <= g;
                ptr    <= g + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter with a behavioural pick model.
module tb_rr_mux_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;

    int nvec;
    int nerr;

    logic [W+1:0] sbq[$];
    int           m_ptr;
    logic         m_full;

    rr_mux_arbiter #(
        .N_REQ(N),
        .W    (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        req_data = {d3, d2, d1, d0};
    endtask

    task automatic model_reset();
        sbq.delete();
        m_ptr  = 0;
        m_full = 1'b0;
    endtask

    // Caller drives inputs while clk is low; evaluated just before the edge.
    task automatic cycle();
        int           g;
        logic         any;
        logic         ld;
        logic [N-1:0] exp_rdy;
        logic [W+1:0] fr;
        #1;
        any = |req_valid;
        g = 0;
        for (int k = N - 1; k >= 0; k--)
            if (req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        ld = any && (!m_full || out_ready);
        exp_rdy = '0;
        if (ld) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_full));
        if (m_full) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                fr = sbq[0];
                chk("out_data", 32'(out_data), 32'(fr[W+1:2]));
                chk("out_src", 32'(out_src), 32'(fr[1:0]));
                if (out_ready) void'(sbq.pop_front());
            end
        end
        if (ld) begin
            sbq.push_back({req_data[g*W +: W], 2'(g)});
            m_ptr  = (g + 1) % N;
            m_full = 1'b1;
        end else if (m_full && out_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        model_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        repeat (2) cycle();

        set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        repeat (10) cycle();
        req_valid = '0;
        cycle();

        set_data(8'h00, 8'h00, 8'h5C, 8'h00);
        req_valid = 4'b0100;
        out_ready = 1'b0;
        repeat (6) cycle();
        out_ready = 1'b1;
        cycle();
        req_valid = '0;
        cycle();

        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        req_valid = 4'b1000;
        cycle();
        req_valid = 4'b1010;
        repeat (2) cycle();
        req_valid = '0;
        cycle();

        set_data(8'h77, 8'h00, 8'h00, 8'h00);
        req_valid = 4'b0001;
        cycle();
        set_data(8'h78, 8'h00, 8'h00, 8'h00);
        cycle();
        req_valid = '0;
        cycle();

        set_data(8'h21, 8'h22, 8'h23, 8'h24);
        req_valid = 4'b0100;
        out_ready = 1'b0;
        repeat (2) cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_src", 32'(out_src), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1010;
        out_ready = 1'b1;
        repeat (3) cycle();
        req_valid = '0;
        cycle();

        for (int n = 0; n < 200; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = 32'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        req_valid = '0;
        out_ready = 1'b1;
        repeat (2) cycle();
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one W-bit output channel between N_REQ requesters by sequencing a select-driven mux. Each requester offers a word with a valid/ready handshake. The arbiter picks one requester fairly, captures its word into a single output register and presents it downstream with valid/ready. It is the controller that would drive the select of the 2:1/N:1 mux datapaths in this area of the design.

Parameters:
N_REQ, 4, number of requesters; must be ≥2 and a power of two.
W, 8, data width per requester.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  reset, asynchronous, active-high.
req_valid  input  N_REQ  bit i: requester i offers a word.
req_data  input  N_REQ*W  requester i word at bits [i*W +: W].
req_ready  output  N_REQ  bit i: requester i word accepted this cycle; one-hot or zero.
out_valid  output  1  output register holds a word.
out_data  output  W  held word.
out_src  output  $clog2(N_REQ)  index of the requester that supplied out_data.
out_ready  input  1  downstream accepts the word when out_valid is also 1.

Behaviour:
- The reset values are out_valid=0, out_data=0, out_src=0 and ptr=0. An internal pointer ptr, $clog2(N_REQ) bits wide, holds the highest-priority index.
- Two states, tracked by out_valid. In EMPTY (out_valid=0) the output register is free. In FULL (out_valid=1) it holds a word awaiting out_ready.
- load = any(req_valid) && (!out_valid || out_ready). Back-to-back transfers are allowed, so a drain and a load can happen in the same cycle.
- Pick rule: g is the first index i with req_valid[i]=1, searching ptr, ptr+1, … and wrapping modulo N_REQ.
- req_ready is combinational: req_ready[g]=load; every other bit is 0. req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- On a load, the next edge sets out_data ← req_data[g], out_src ← g, out_valid ← 1 and ptr ← (g+1) mod N_REQ. The wrap comes from natural overflow.
- On a drain without a load (out_valid && out_ready && !any(req_valid)), the next edge sets out_valid ← 0. out_data and out_src keep their old values, and ptr is unchanged.
- FULL && !out_ready: hold everything, with req_ready=0. out_data and out_src must stay stable while out_valid=1 and out_ready=0.
- Latency: a word accepted at edge k appears on out_data after edge k. The minimum request-to-output latency is 1 cycle. Throughput is 1 word/cycle when out_ready is held at 1.
- Fairness: a requester holding req_valid=1 is granted within N_REQ loads.
- Single requester: it is granted on every load, and ptr keeps advancing past it.
- Request dropped before grant: no effect, since no state depends on unaccepted requests.
- Reset mid-operation: the held word is discarded, and outputs and ptr return to their reset values immediately (asynchronous).
- No X propagation: when req_valid=0, g is don't-care, but req_ready must be all-zero.

Decomposition:
- Shared package rr_mux_pkg holds the default constants N_REQ_DEF=4 and W_DEF=8, plus the typedef idx_t = logic [$clog2(N_REQ)-1:0] for ptr, g and out_src.
- Sub-module rr_pick: combinational. Inputs are valid[N_REQ] and ptr. Outputs are any and grant index g. It is implemented as a rotate-right by ptr, a find-first-set, then an add of ptr modulo N_REQ.
- The top level holds the ptr register, the output register, load logic and the req_data select mux.

Test Plan:
1. Reset → during rst=1 and after release with no requests: out_valid=0, out_data=0, out_src=0, req_ready=0000.
2. All four requesters valid continuously, data 8'hA0..8'hA3, out_ready=1 → one word per cycle with out_src sequence 0,1,2,3,0,…, data A0,A1,A2,A3,A0. Each req_ready is one-hot, in the same order.
3. Backpressure: req_valid=0100, data 8'h5C, out_ready=0 for 5 cycles → out_valid=1, out_data=5C and out_src=2 stay stable. req_ready=0000 during the stall. The word drains on the cycle out_ready=1.
4. Wrap/priority: after a grant to index 3 (ptr=0), req_valid=1010 → next grant is index 1, then index 3. Confirms ptr wraps from 3 to 0.
5. Simultaneous drain+load: FULL with out_ready=1 and req_valid=0001 → req_ready=0001 in the same cycle, out_valid stays 1, and out_data updates to requester 0's word on the next edge.
6. Async reset mid-transfer: assert rst between edges while FULL → out_valid=0 immediately, without waiting for clk. After release, the first grant goes to the lowest valid index starting from 0.
